// File: rtl/utf8_stream_if.sv
// Byte-in / code-point-out stream bundle for the UTF-8 decoder.
// The decoder sits on the slave side; the byte source and the character consumer sit on the
// master side.
interface utf8_stream_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_eof;
  logic [20:0]     out_cp;
  logic [3:0]      out_err;
  logic            out_valid;
  logic            out_ready;
  logic [LvlW-1:0] level;
  logic            busy;

  modport slave (
    input  in_data, in_valid, in_eof, out_ready,
    output in_ready, out_cp, out_err, out_valid, level, busy
  );

  modport master (
    output in_data, in_valid, in_eof, out_ready,
    input  in_ready, out_cp, out_err, out_valid, level, busy
  );
endinterface

// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 to code-point decoder with a first-word fall-through output FIFO.
// Error record bits are {truncated, nonuni, overlong, invalid}.
module utf8_stream_decoder #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          CHK_RANGE = 1'b1,
  parameter bit          REPLACE   = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  utf8_stream_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [3:0] ErrTrunc    = 4'b1000;
  localparam logic [3:0] ErrNonuni   = 4'b0100;
  localparam logic [3:0] ErrOverlong = 4'b0010;
  localparam logic [3:0] ErrInvalid  = 4'b0001;

  typedef enum logic {StIdle, StCont} state_e;

  state_e          state_q, state_d;
  logic [14:0]     acc_q, acc_d;
  logic [1:0]      need_q, need_d;
  logic [2:0]      len_q, len_d;
  logic            replay_q, replay_d;
  logic [7:0]      rbyte_q, rbyte_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [24:0]     mem_q [DEPTH];

  logic        space, accept, eof_take, replay_go, lead_go, cont_go;
  logic        push, pop, ovl, nonuni;
  logic [7:0]  cur_byte;
  logic [20:0] full_v, push_cp, rec_cp;
  logic [3:0]  push_err;

  // Handshake, byte decode and next-state; a replayed byte is treated exactly like a lead byte.
  always_comb begin
    space        = level_q < LvlW'(DEPTH);
    bus.in_ready = rst_n & ~replay_q & space;
    accept       = bus.in_valid & bus.in_ready;
    eof_take     = ~bus.in_valid & bus.in_ready & bus.in_eof;
    replay_go    = replay_q & space;
    cur_byte     = replay_q ? rbyte_q : bus.in_data;
    lead_go      = replay_go | (accept & (state_q == StIdle));
    cont_go      = accept & (state_q == StCont);
    full_v       = {acc_q, cur_byte[5:0]};

    ovl = 1'b0;
    case (len_q)
      3'd2:    ovl = full_v < 21'h80;
      3'd3:    ovl = full_v < 21'h800;
      default: ovl = full_v < 21'h10000;
    endcase
    nonuni = ((full_v >= 21'hD800) && (full_v <= 21'hDFFF)) ||
             (CHK_RANGE && (full_v > 21'h10FFFF));

    state_d  = state_q;
    acc_d    = acc_q;
    need_d   = need_q;
    len_d    = len_q;
    replay_d = replay_q;
    rbyte_d  = rbyte_q;
    push     = 1'b0;
    push_cp  = '0;
    push_err = '0;

    if (lead_go) begin
      replay_d = 1'b0;
      if (!cur_byte[7]) begin
        push    = 1'b1;
        push_cp = {13'd0, cur_byte};
      end else if (cur_byte[7:5] == 3'b110) begin
        acc_d   = {10'd0, cur_byte[4:0]};
        need_d  = 2'd1;
        len_d   = 3'd2;
        state_d = StCont;
      end else if (cur_byte[7:4] == 4'b1110) begin
        acc_d   = {11'd0, cur_byte[3:0]};
        need_d  = 2'd2;
        len_d   = 3'd3;
        state_d = StCont;
      end else if (cur_byte[7:3] == 5'b11110) begin
        acc_d   = {12'd0, cur_byte[2:0]};
        need_d  = 2'd3;
        len_d   = 3'd4;
        state_d = StCont;
      end else begin
        push     = 1'b1;
        push_cp  = {13'd0, cur_byte};
        push_err = ErrInvalid;
      end
    end else if (cont_go) begin
      if (cur_byte[7:6] == 2'b10) begin
        acc_d  = full_v[14:0];
        need_d = need_q - 2'd1;
        if (need_q == 2'd1) begin
          push     = 1'b1;
          push_cp  = full_v;
          push_err = (ovl ? ErrOverlong : 4'b0) | (nonuni ? ErrNonuni : 4'b0);
          state_d  = StIdle;
        end
      end else begin
        // The truncation record takes this cycle's push; the byte is re-decoded next cycle.
        push     = 1'b1;
        push_err = ErrTrunc;
        replay_d = 1'b1;
        rbyte_d  = cur_byte;
        state_d  = StIdle;
      end
    end else if (eof_take && (state_q == StCont)) begin
      push     = 1'b1;
      push_err = ErrTrunc;
      state_d  = StIdle;
    end

    rec_cp = (REPLACE && (push_err != 4'b0)) ? 21'h00FFFD : push_cp;

    pop    = (level_q != '0) & bus.out_ready;
    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end else begin
      level_d = level_q;
    end
  end

  // FIFO head and status outputs; the head is masked to zero while empty.
  always_comb begin
    bus.out_valid = level_q != '0;
    bus.out_cp    = bus.out_valid ? mem_q[rptr_q][20:0] : '0;
    bus.out_err   = bus.out_valid ? mem_q[rptr_q][24:21] : '0;
    bus.level     = level_q;
    bus.busy      = (state_q == StCont) | replay_q;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      need_q   <= '0;
      len_q    <= '0;
      replay_q <= 1'b0;
      rbyte_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      need_q   <= need_d;
      len_q    <= len_d;
      replay_q <= replay_d;
      rbyte_q  <= rbyte_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; contents are don't-care until the level says otherwise.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wptr_q] <= {push_err, rec_cp};
    end
  end
endmodule

// File: doc/utf8_stream_decoder.md
Name: utf8_stream_decoder

Overview:
- Streaming UTF-8 to code-point decoder with valid/ready handshakes on both sides and a parametrised output FIFO.
- Successor to the single-character hardware_utf8 transcoder. Adds back-pressure, buffering of DEPTH decoded characters, truncation detection on end-of-stream, and optional U+FFFD replacement.
- Sits between a byte source (host bus or UART) and the character-property and UTF-16 logic.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, ≥2.
- CHK_RANGE, 1, when 1, values ≥0x110000 set the nonuni error.
- REPLACE, 0, when 1, any record with a nonzero error has out_cp forced to 0x00FFFD.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- in_data  input  8  UTF-8 byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  byte accepted on an edge where in_valid=1 and in_ready=1.
- in_eof  input  1  end-of-stream pulse; honoured only when in_valid=0 and in_ready=1.
- out_cp  output  21  decoded code point of the FIFO head.
- out_err  output  4  {truncated, nonuni, overlong, invalid} of the FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  pops the head when out_valid=1.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  mid-sequence (state CONT) or replay pending.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, FIFO empty, replay clear. Outputs: out_valid=0, out_cp=0, out_err=0, level=0, busy=0. in_ready=0 while rst_n=0.
- in_ready = rst_n & ~replay & (level < DEPTH). It does not depend on out_ready: a full FIFO stalls input even when a pop happens in the same cycle.
- FIFO: first-word fall-through. Push and pop in the same cycle are allowed; level is unchanged. Pointers wrap modulo DEPTH.
- Latency: a record written at edge N is visible on out_* from edge N; out_valid is high in cycle N+1.
- States:
  - IDLE, lead byte accepted:
    - 00-7F: push {cp=byte, err=0}.
    - C0-DF: acc=byte[4:0], need=1, len=2, go to CONT.
    - E0-EF: acc=byte[3:0], need=2, len=3, go to CONT.
    - F0-F7: acc=byte[2:0], need=3, len=4, go to CONT.
    - 80-BF or F8-FF: push {cp=byte, err=invalid}.
  - CONT, continuation byte (80-BF) accepted: acc={acc,byte[5:0]}, need-1. When need reaches 0, push the completed value with these checks:
    - overlong if value < min(len), where min = 0x80, 0x800, 0x10000 for len 2, 3, 4.
    - nonuni if value is in D800-DFFF, or if CHK_RANGE and value > 0x10FFFF.
    - Then return to IDLE.
  - CONT, non-continuation byte accepted: push {cp=0, err=truncated}. The byte goes to the replay register and the state returns to IDLE. Next cycle: in_ready=0, the replay byte is processed as a lead byte, and replay clears.
  - CONT, in_eof honoured: push {cp=0, err=truncated}, go to IDLE.
  - IDLE, in_eof honoured: no-op.
- Error bits may combine (e.g. overlong and nonuni together).
- REPLACE=1 forces cp=0x00FFFD on any nonzero err; err is still reported.
- At most one FIFO push per cycle. A push only occurs on a cycle in which a byte is accepted or replayed, and in_ready already guarantees space for it. A replay cycle runs only after a truncation, whose push has just consumed one slot.
- Replay needs a free slot before it proceeds: if level=DEPTH, replay waits, with busy=1 and in_ready=0.
- Reset mid-sequence discards the partial sequence, the replay byte and all FIFO contents; nothing is emitted.

Test Plan:
- Stream 41 C3 A9 E2 82 AC F0 9F 98 80 with out_ready=1 -> records 0x41, 0xE9, 0x20AC, 0x1F600, all err=0; each out_valid appears one cycle after the final byte is accepted.
- C0 81, E0 80 80, ED A0 80, F4 90 80 80 (CHK_RANGE=1) -> {0x01, overlong}, {0x000, overlong}, {0xD800, nonuni}, {0x110000, nonuni}. With REPLACE=1, all four cp=0xFFFD with the same errs.
- Bytes 80, FF, then E2 82 41 -> {0x80, invalid}, {0xFF, invalid}, {0, truncated}, {0x41, 0}. in_ready=0 for exactly one cycle after 41 is accepted.
- E2 82 then an in_eof pulse -> {0, truncated}, busy drops to 0; an in_eof in IDLE produces no record.
- DEPTH=4, out_ready=0, feed 6 ASCII bytes -> level=4, in_ready=0 after the 4th. Raise out_ready for one cycle -> one pop, no push that cycle; 5th byte accepted the next cycle. Order preserved.
- Assert rst_n=0 after F0 9F with 2 records queued -> next edge: level=0, out_valid=0, busy=0. Then feed 41 -> {0x41, 0}.
